// File: rtl/dot_operand_reader_pkg.sv
// Shared definitions for the dot-product FIFO datapath (reader, writer FSM, multiplier).
package dot_operand_reader_pkg;

    localparam int VALUE_WIDTH   = 8;
    // Element count for the default 16-bit word.
    localparam int VECTOR_LENGTH = 16 / VALUE_WIDTH;
    // Cycles from FIFO pop to the operand strobe.
    localparam int RD_LATENCY    = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dot_operand_reader.sv
// Read side of the dot-product FIFO datapath: pops operand pairs from two FIFOs
// and presents them, registered, to the multiplier with a one-cycle strobe.
module dot_operand_reader
    import dot_operand_reader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDRESS_WIDTH:0] num_vectors,
    input  logic                   fifo1_empty,
    output logic                   fifo1_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo1_dout,
    input  logic                   fifo2_empty,
    output logic                   fifo2_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo2_dout,
    output logic [DATA_WIDTH-1:0]  inputVector1,
    output logic [DATA_WIDTH-1:0]  inputVector2,
    output logic                   done_reading,
    output logic                   busy,
    output logic                   finished,
    output logic [ADDRESS_WIDTH:0] vec_count
);

    localparam int CW = ADDRESS_WIDTH + 1;

    state_t              state, state_nxt;
    logic [CW-1:0]       target;
    logic [CW-1:0]       issued;
    logic [RD_LATENCY:1] vld_pipe;  // [1] is rd_pending, [RD_LATENCY] is the strobe
    logic                pop;
    logic                accept;

    assign accept = (state == ST_IDLE) && start;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = (num_vectors == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                // Both FIFOs are popped together so the pair stays aligned.
                pop = !fifo1_empty && !fifo2_empty && (issued < target);
                if (vec_count == target) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            target       <= '0;
            issued       <= '0;
            vec_count    <= '0;
            vld_pipe     <= '0;
            inputVector1 <= '0;
            inputVector2 <= '0;
        end else begin
            state    <= state_nxt;
            vld_pipe <= {vld_pipe[RD_LATENCY-1:1], pop};
            if (accept) begin
                target    <= num_vectors;
                issued    <= '0;
                vec_count <= '0;
            end else begin
                if (pop) issued <= issued + CW'(1);
                // FIFO data lands the cycle after the pop; capture it then.
                if (vld_pipe[1]) begin
                    inputVector1 <= fifo1_dout;
                    inputVector2 <= fifo2_dout;
                    vec_count    <= vec_count + CW'(1);
                end
            end
        end
    end

    assign fifo1_rd_en  = pop;
    assign fifo2_rd_en  = pop;
    assign done_reading = vld_pipe[RD_LATENCY];
    assign busy         = (state != ST_IDLE);
    assign finished     = (state == ST_DONE);

endmodule

// File: tb/tb_dot_operand_reader.sv
// Bench for dot_operand_reader: queue-based FIFO models, a transaction-level
// reference model checked every cycle, a run table, directed corners and random runs.
module tb_dot_operand_reader;

    typedef enum int { M_IDLE, M_RUN, M_DONE } mphase_t;
    typedef struct { int due; logic [15:0] a; logic [15:0] b; } pend_t;
    typedef struct { int num; int words; int exp_pairs; int exp_fin; int exp_count; } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  num_vectors = '0;
    logic        fifo1_empty = 1'b1, fifo2_empty = 1'b1;
    logic        fifo1_rd_en, fifo2_rd_en;
    logic [15:0] fifo1_dout = '0, fifo2_dout = '0;
    logic [15:0] inputVector1, inputVector2;
    logic        done_reading, busy, finished;
    logic [8:0]  vec_count;

    dot_operand_reader #(.ADDRESS_WIDTH(8), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
        .fifo1_empty(fifo1_empty), .fifo1_rd_en(fifo1_rd_en), .fifo1_dout(fifo1_dout),
        .fifo2_empty(fifo2_empty), .fifo2_rd_en(fifo2_rd_en), .fifo2_dout(fifo2_dout),
        .inputVector1(inputVector1), .inputVector2(inputVector2),
        .done_reading(done_reading), .busy(busy), .finished(finished), .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    logic [15:0] q1[$], q2[$];
    pend_t       pend[$];
    logic [31:0] slog[$];
    mphase_t     phase = M_IDLE;
    int          m_num = 0, m_issued = 0, m_deliv = 0;
    logic [15:0] m_v1 = '0, m_v2 = '0;
    int          cyc = 0;
    bit          chk_en = 1'b0;
    int          n_vec = 0, n_err = 0;
    int          obs_pop = 0, obs_str = 0, obs_fin = 0, first_pop = -1, first_str = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push1(input logic [15:0] v); q1.push_back(v); fifo1_empty = 1'b0; endtask
    task automatic push2(input logic [15:0] v); q2.push_back(v); fifo2_empty = 1'b0; endtask

    task automatic flush();
        q1.delete(); q2.delete();
        fifo1_empty = 1'b1; fifo2_empty = 1'b1;
    endtask

    task automatic clr_obs();
        obs_pop = 0; obs_str = 0; obs_fin = 0; first_pop = -1; first_str = -1;
        slog.delete();
    endtask

    // One clock: sample and check mid-cycle, advance the model, then update the FIFOs.
    task automatic step();
        bit      exp_str, exp_pop, p1, p2;
        pend_t   pe;
        mphase_t nxt;
        #3;
        exp_str = (pend.size() > 0) && (pend[0].due == cyc);
        if (exp_str) begin
            pe = pend.pop_front();
            m_deliv++; m_v1 = pe.a; m_v2 = pe.b;
        end
        exp_pop = (phase == M_RUN) && (q1.size() > 0) && (q2.size() > 0) && (m_issued < m_num);
        if (chk_en) begin
            chk("done_reading", {31'd0, done_reading}, {31'd0, exp_str});
            chk("inputVector1", {16'd0, inputVector1}, {16'd0, m_v1});
            chk("inputVector2", {16'd0, inputVector2}, {16'd0, m_v2});
            chk("vec_count", {23'd0, vec_count}, m_deliv);
            chk("busy", {31'd0, busy}, {31'd0, phase != M_IDLE});
            chk("finished", {31'd0, finished}, {31'd0, phase == M_DONE});
            chk("fifo1_rd_en", {31'd0, fifo1_rd_en}, {31'd0, exp_pop});
            chk("fifo2_rd_en", {31'd0, fifo2_rd_en}, {31'd0, exp_pop});
        end
        if (done_reading) begin
            obs_str++;
            slog.push_back({inputVector1, inputVector2});
            if (first_str < 0) first_str = cyc;
        end
        if (finished) obs_fin++;
        p1 = fifo1_rd_en; p2 = fifo2_rd_en;
        if (p1) begin
            obs_pop++;
            if (first_pop < 0) first_pop = cyc;
        end
        if (p1 && p2 && q1.size() > 0 && q2.size() > 0)
            pend.push_back('{cyc + 2, q1[0], q2[0]});
        nxt = phase;
        case (phase)
            M_IDLE: if (start) begin
                m_num = int'(num_vectors); m_issued = 0; m_deliv = 0;
                nxt = (num_vectors == 0) ? M_DONE : M_RUN;
            end
            M_RUN:  if (m_deliv == m_num) nxt = M_DONE;
            default: nxt = M_IDLE;
        endcase
        if (exp_pop) m_issued++;
        if (rst) begin
            nxt = M_IDLE; m_num = 0; m_issued = 0; m_deliv = 0;
            m_v1 = '0; m_v2 = '0; pend.delete();
        end
        @(posedge clk);
        cyc++;
        phase = nxt;
        if (rst) chk_en = 1'b1;
        #1;
        if (p1 && q1.size() > 0) fifo1_dout = q1.pop_front();
        if (p2 && q2.size() > 0) fifo2_dout = q2.pop_front();
        fifo1_empty = (q1.size() == 0);
        fifo2_empty = (q2.size() == 0);
        #1;
    endtask

    task automatic run(input int num, input int budget);
        num_vectors = 9'(num); start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < budget && busy; i++) step();
        chk("run_completes", {31'd0, busy}, 32'd0);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1, 1, 1, 1, 1};
        tbl[1] = '{5, 5, 5, 1, 5};
        tbl[2] = '{2, 4, 2, 1, 2};
        tbl[3] = '{0, 2, 0, 1, 0};
        tbl[4] = '{7, 9, 7, 1, 7};
        tbl[5] = '{256, 256, 256, 1, 256};

        // Reset held with data present: nothing may be popped or strobed.
        push1(16'h1234); push2(16'h5678);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("rst_rd_en", {31'd0, fifo1_rd_en}, 32'd0);
        chk("rst_done_reading", {31'd0, done_reading}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_finished", {31'd0, finished}, 32'd0);
        chk("rst_vec_count", {23'd0, vec_count}, 32'd0);
        rst = 1'b0;
        flush();
        step();

        // Burst of three known pairs.
        push1(16'h0102); push1(16'h0304); push1(16'h0506);
        push2(16'h0A0B); push2(16'h0C0D); push2(16'h0E0F);
        clr_obs();
        run(3, 20);
        chk("burst_pops", obs_pop, 3);
        chk("burst_strobes", obs_str, 3);
        chk("burst_finished", obs_fin, 1);
        chk("burst_latency", first_str - first_pop, 2);
        chk("burst_pair0", slog[0], 32'h0102_0A0B);
        chk("burst_pair1", slog[1], 32'h0304_0C0D);
        chk("burst_pair2", slog[2], 32'h0506_0E0F);
        chk("burst_vec_count", {23'd0, vec_count}, 3);

        // Stall on an empty FIFO2, then release it.
        flush(); clr_obs();
        push1(16'h1111); push1(16'h2222);
        num_vectors = 9'd2; start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("stall_no_pop", obs_pop, 0);
        chk("stall_busy", {31'd0, busy}, 1);
        push2(16'hAAAA); push2(16'hBBBB);
        for (int i = 0; i < 20 && busy; i++) step();
        chk("stall_strobes", obs_str, 2);
        chk("stall_finished", obs_fin, 1);
        chk("stall_pair0", slog[0], 32'h1111_AAAA);
        chk("stall_pair1", slog[1], 32'h2222_BBBB);

        // Zero-length run.
        flush(); clr_obs();
        run(0, 10);
        chk("zero_pops", obs_pop, 0);
        chk("zero_finished", obs_fin, 1);
        chk("zero_vec_count", {23'd0, vec_count}, 0);

        // Second start while busy must be ignored.
        clr_obs();
        for (int i = 0; i < 3; i++) begin push1(16'(i + 16'h40)); push2(16'(i + 16'h80)); end
        num_vectors = 9'd3; start = 1'b1; step(); start = 1'b0;
        step();
        num_vectors = 9'd7; start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 20 && busy; i++) step();
        chk("busy_start_strobes", obs_str, 3);
        chk("busy_start_finished", obs_fin, 1);
        chk("busy_start_vec_count", {23'd0, vec_count}, 3);

        // Reset the cycle after the second pop of a four-pair run.
        flush(); clr_obs();
        for (int i = 0; i < 4; i++) begin push1(16'(i + 16'h100)); push2(16'(i + 16'h200)); end
        num_vectors = 9'd4; start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 10 && obs_pop < 2; i++) step();
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("midrst_strobes", obs_str, 1);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_vec_count", {23'd0, vec_count}, 0);
        chk("midrst_vector1", {16'd0, inputVector1}, 0);
        flush(); clr_obs();
        push1(16'h7777); push2(16'h8888);
        run(1, 10);
        chk("postrst_strobes", obs_str, 1);
        chk("postrst_finished", obs_fin, 1);
        chk("postrst_pair", slog[0], 32'h7777_8888);

        // Table of runs with random payloads.
        for (int t = 0; t < 6; t++) begin
            flush(); clr_obs();
            for (int w = 0; w < tbl[t].words; w++) begin
                push1(16'($urandom)); push2(16'($urandom));
            end
            run(tbl[t].num, tbl[t].num + 20);
            chk($sformatf("tbl%0d_pairs", t), obs_str, tbl[t].exp_pairs);
            chk($sformatf("tbl%0d_finished", t), obs_fin, tbl[t].exp_fin);
            chk($sformatf("tbl%0d_vec_count", t), {23'd0, vec_count}, tbl[t].exp_count);
        end

        // Random runs: trickled data, random stalls, stray starts while busy.
        for (int r = 0; r < 40; r++) begin
            int num, n1, n2;
            flush(); clr_obs();
            num = $urandom_range(0, 10);
            n1 = 0; n2 = 0;
            num_vectors = 9'(num); start = 1'b1; step(); start = 1'b0;
            for (int i = 0; i < 400 && busy; i++) begin
                if (n1 < num && $urandom_range(0, 2) == 0) begin push1(16'($urandom)); n1++; end
                if (n2 < num && $urandom_range(0, 2) == 0) begin push2(16'($urandom)); n2++; end
                start = ($urandom_range(0, 7) == 0);
                num_vectors = 9'($urandom_range(0, 511));
                step();
                start = 1'b0;
            end
            chk("rand_completes", {31'd0, busy}, 0);
            chk("rand_pairs", obs_str, num);
            chk("rand_finished", obs_fin, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
